// File: rtl/imul_iter.sv
// Iterative shift-add multiplier that returns the low NBITS of a*b.
// One operation in flight, with val/rdy handshakes on the request and response ports.
module imul_iter #(
  parameter int NBITS      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [2*NBITS-1:0] req_msg,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [NBITS-1:0]   resp_msg
);

  localparam int CNTW = $clog2(NBITS) + 1;
  localparam logic [CNTW-1:0] LAST_STEP = CNTW'(NBITS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  logic [NBITS-1:0] r_a;
  logic [NBITS-1:0] r_b;
  logic [NBITS-1:0] r_result;
  logic [CNTW-1:0]  r_cnt;

  logic [NBITS-1:0] w_a_in;
  logic [NBITS-1:0] w_b_in;
  logic [NBITS-1:0] w_b_next;
  logic             w_last;

  assign w_a_in   = req_msg[2*NBITS-1:NBITS];
  assign w_b_in   = req_msg[NBITS-1:0];
  assign w_b_next = r_b >> 1;
  // Finish on the final bit position, or early once no multiplier bits remain.
  assign w_last   = (r_cnt == LAST_STEP) || (EARLY_EXIT && (w_b_next == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (req_val) begin
            r_a      <= w_a_in;
            r_b      <= w_b_in;
            r_result <= '0;
            r_cnt    <= '0;
            r_state  <= (EARLY_EXIT && (w_b_in == '0)) ? DONE : CALC;
          end
        end
        CALC: begin
          if (r_b[0]) begin
            r_result <= r_result + r_a;
          end
          r_a   <= r_a << 1;
          r_b   <= w_b_next;
          r_cnt <= r_cnt + CNTW'(1);
          if (w_last) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (resp_rdy) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake outputs depend only on the state register.
  assign req_rdy  = (r_state == IDLE);
  assign resp_val = (r_state == DONE);
  assign resp_msg = r_result;

endmodule

// File: tb/tb_imul_iter.sv
// Directed and randomized bench for imul_iter.
// Unit 0 is built with fixed latency and unit 1 with early exit.
module tb_imul_iter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  reqVal;
  logic [1:0]  reqRdy;
  logic [63:0] reqMsg [2];
  logic [1:0]  respVal;
  logic [1:0]  respRdy;
  logic [31:0] respMsg [2];

  int totalChecks = 0;
  int badChecks   = 0;

  imul_iter #(.NBITS(32), .EARLY_EXIT(1'b0)) dutFixed (
    .clk(clk), .rst_n(rst_n),
    .req_val(reqVal[0]), .req_rdy(reqRdy[0]), .req_msg(reqMsg[0]),
    .resp_val(respVal[0]), .resp_rdy(respRdy[0]), .resp_msg(respMsg[0])
  );

  imul_iter #(.NBITS(32), .EARLY_EXIT(1'b1)) dutEarly (
    .clk(clk), .rst_n(rst_n),
    .req_val(reqVal[1]), .req_rdy(reqRdy[1]), .req_msg(reqMsg[1]),
    .resp_val(respVal[1]), .resp_rdy(respRdy[1]), .resp_msg(respMsg[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // A unit must never offer to accept while it is presenting a result.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("rdyValExcl0", {63'd0, reqRdy[0] & respVal[0]}, 64'd0);
      checkOutput("rdyValExcl1", {63'd0, reqRdy[1] & respVal[1]}, 64'd0);
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for the response, optionally stall the
  // consumer, then drain it. expLat < 0 skips the latency comparison.
  task automatic applyStimulus(input int u, input logic [31:0] a, input logic [31:0] b,
                               input int expLat, input logic [31:0] expProd,
                               input int respDelay);
    int guard;
    int cycles;
    guard = 0;
    while (!reqRdy[u] && guard < 50) begin
      stepCycle();
      guard++;
    end
    checkOutput("reqRdyBeforeIssue", {63'd0, reqRdy[u]}, 64'd1);
    reqVal[u] = 1'b1;
    reqMsg[u] = {a, b};
    stepCycle();
    reqVal[u] = 1'b0;
    reqMsg[u] = '0;
    cycles = 1;
    while (!respVal[u] && cycles < 100) begin
      stepCycle();
      cycles++;
    end
    checkOutput("respTimeout", {63'd0, respVal[u]}, 64'd1);
    if (expLat >= 0) begin
      checkOutput("latency", 64'(cycles), 64'(expLat));
    end
    checkOutput("product", {32'd0, respMsg[u]}, {32'd0, expProd});
    repeat (respDelay) begin
      stepCycle();
      checkOutput("stallVal", {63'd0, respVal[u]}, 64'd1);
      checkOutput("stallMsg", {32'd0, respMsg[u]}, {32'd0, expProd});
    end
    respRdy[u] = 1'b1;
    stepCycle();
    respRdy[u] = 1'b0;
    checkOutput("reqRdyAfterDrain", {63'd0, reqRdy[u]}, 64'd1);
    checkOutput("respValAfterDrain", {63'd0, respVal[u]}, 64'd0);
  endtask

  initial begin
    int cycles;
    logic sawResp;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rp;

    rst_n      = 1'b0;
    reqVal     = '0;
    respRdy    = '0;
    reqMsg[0]  = '0;
    reqMsg[1]  = '0;
    #1;
    for (int u = 0; u < 2; u++) begin
      checkOutput("rstReqRdy", {63'd0, reqRdy[u]}, 64'd1);
      checkOutput("rstRespVal", {63'd0, respVal[u]}, 64'd0);
      checkOutput("rstRespMsg", {32'd0, respMsg[u]}, 64'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stepCycle();

    // Fixed-latency unit: always NBITS+1 cycles.
    applyStimulus(0, 32'd3, 32'd4, 33, 32'd12, 0);
    applyStimulus(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0001, 0);
    applyStimulus(0, 32'h8000_0000, 32'd2, 33, 32'h0000_0000, 0);
    applyStimulus(0, 32'd7, 32'd0, 33, 32'd0, 0);

    // Early-exit unit: latency follows the highest set multiplier bit.
    applyStimulus(1, 32'd7, 32'd0, 1, 32'd0, 0);
    applyStimulus(1, 32'd5, 32'd6, 4, 32'd30, 0);
    applyStimulus(1, 32'd1, 32'h8000_0000, 33, 32'h8000_0000, 0);
    applyStimulus(1, 32'hFFFF_FFFF, 32'd1, 2, 32'hFFFF_FFFF, 0);

    // Backpressure with the next request already waiting.
    reqVal[1] = 1'b1;
    reqMsg[1] = {32'd5, 32'd6};
    stepCycle();
    reqMsg[1] = {32'd2, 32'd3};
    cycles = 1;
    while (!respVal[1] && cycles < 100) begin
      stepCycle();
      cycles++;
    end
    checkOutput("bpLatency", 64'(cycles), 64'd4);
    repeat (5) begin
      checkOutput("bpVal", {63'd0, respVal[1]}, 64'd1);
      checkOutput("bpMsg", {32'd0, respMsg[1]}, 64'd30);
      checkOutput("bpReqRdy", {63'd0, reqRdy[1]}, 64'd0);
      stepCycle();
    end
    respRdy[1] = 1'b1;
    stepCycle();
    respRdy[1] = 1'b0;
    checkOutput("bpIdleReqRdy", {63'd0, reqRdy[1]}, 64'd1);
    stepCycle();
    reqVal[1] = 1'b0;
    checkOutput("bpSecondAccepted", {63'd0, reqRdy[1]}, 64'd0);
    cycles = 1;
    while (!respVal[1] && cycles < 100) begin
      stepCycle();
      cycles++;
    end
    checkOutput("bpSecondLatency", 64'(cycles), 64'd3);
    checkOutput("bpSecondMsg", {32'd0, respMsg[1]}, 64'd6);
    respRdy[1] = 1'b1;
    stepCycle();
    respRdy[1] = 1'b0;

    // Asynchronous reset between edges while the fixed unit is mid-calculation.
    reqVal[0] = 1'b1;
    reqMsg[0] = {32'd100, 32'h0000_FFFF};
    stepCycle();
    reqVal[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("midCalcReqRdy", {63'd0, reqRdy[0]}, 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstReqRdy", {63'd0, reqRdy[0]}, 64'd1);
    checkOutput("asyncRstRespVal", {63'd0, respVal[0]}, 64'd0);
    checkOutput("asyncRstRespMsg", {32'd0, respMsg[0]}, 64'd0);
    #1;
    rst_n = 1'b1;
    sawResp = 1'b0;
    repeat (40) begin
      stepCycle();
      if (respVal[0]) sawResp = 1'b1;
    end
    checkOutput("noRespAfterRst", {63'd0, sawResp}, 64'd0);
    applyStimulus(0, 32'd9, 32'd9, 33, 32'd81, 0);

    // Randomized operands, idle gaps and consumer stalls on both units.
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) stepCycle();
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 15) == 0) rb = 32'd0;
      rp = ra * rb;
      applyStimulus(i % 2, ra, rb, -1, rp, int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
